// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and default bit period.
// Used by both the transmit and receive ends of the host serial link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS   = 8;
    // 100 MHz core clock / 115200 baud
    localparam int UART_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with separate occupancy count; read data is the head entry, taken on the pop edge.
// Latency: push visible to empty/count one cycle later; backpressure: push ignored when full, pop ignored when empty.
module uart_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 core_clk,
    input  logic                 arst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wr_dat,
    output logic                 full,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rd_dat,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally; the count disambiguates full from empty.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first; push to start-bit edge is 2 cycles from idle.
// Backpressure: ready = !full from the registered count, no same-cycle bypass on pop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT    = UART_CLK_PER_BIT,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [7:0]                data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      UART_TX,
    output logic                      busy,
    output logic [FIFO_DEPTH_LOG:0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_STOP  = 2'(STOP);

    logic [1:0]                state;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      tx_q;

    logic                      push;
    logic                      pop;
    logic                      bit_end;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dat;

    assign ready   = !fifo_full;
    assign push    = valid && ready;
    assign bit_end = (baud_cnt == BAUD_LAST);
    // Pop from idle, or at the very end of a stop bit to chain frames with no gap.
    assign pop     = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign busy    = (state != ST_IDLE) || !fifo_empty;
    assign UART_TX = tx_q;

    uart_sync_fifo #(
        .WIDTH     (UART_DATA_BITS),
        .DEPTH_LOG (FIFO_DEPTH_LOG)
    ) u_fifo (
        .core_clk (CLK),
        .arst_n   (RST_N),
        .push     (push),
        .wr_dat   (data),
        .full     (fifo_full),
        .pop      (pop),
        .rd_dat   (fifo_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            // Line register trails the state by one cycle, giving the 2-cycle push-to-start latency.
            case (state)
                ST_START: tx_q <= 1'b0;
                ST_DATA:  tx_q <= shift[0];
                default:  tx_q <= 1'b1;
            endcase

            if (state != ST_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_dat;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= fifo_dat;
                            bit_idx <= '0;
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLK_PER_BIT=4, FIFO_DEPTH_LOG=2.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DL    = 2;
    localparam int FRAME = 10 * CPB;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic [7:0]    data  = 8'h00;
    logic          valid = 1'b0;
    logic          ready;
    logic          UART_TX;
    logic          busy;
    logic [DL:0]   fifo_count;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_buffered #(
        .CLK_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG (DL)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Caller is positioned on the first sample of the first start bit; frames must be back-to-back.
    task automatic check_stream(input int n, input string tag);
        logic [9:0] fr;
        logic       exp_bit;
        for (int f = 0; f < n; f++) begin
            fr = {1'b1, exp_q[f], 1'b0};
            for (int i = 0; i < FRAME; i++) begin
                if (f != 0 || i != 0) tick();
                exp_bit = fr[i / CPB];
                checks++;
                if (UART_TX !== exp_bit) begin
                    errors++;
                    $display("FAIL %s frame %0d cycle %0d: UART_TX=%b expected %b", tag, f, i, UART_TX, exp_bit);
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        RST_N = 1'b0;
        valid = 1'b0;
        repeat (3) tick();
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", UART_TX); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        RST_N = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (UART_TX !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle_line: %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single();
        data  = 8'hA5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 8'h00;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d expected 1", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_pop: got %0d expected 0", fifo_count); end
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL single_tx_t1: got %b expected 1", UART_TX); end
        tick();
        exp_q = {8'hA5};
        check_stream(1, "single");
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        repeat (3) tick();
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL single_tx_after: got %b expected 1", UART_TX); end
    endtask

    task automatic test_burst();
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    data  = 8'(i + 1);
                    valid = 1'b1;
                    checks++;
                    if (ready !== 1'b1) begin errors++; $display("FAIL burst_ready_push%0d: got %b expected 1", i, ready); end
                    tick();
                end
                valid = 1'b0;
                data  = 8'h00;
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL burst_count_full: got %0d expected 4", fifo_count); end
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL burst_ready_full: got %b expected 0", ready); end
            end
            begin
                repeat (3) tick();
                check_stream(5, "burst");
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b expected 0", busy); end
                checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL burst_count_end: got %0d expected 0", fifo_count); end
            end
        join
        repeat (2) tick();
    endtask

    task automatic test_simul();
        exp_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        fork
            begin
                data  = 8'hA1; valid = 1'b1; tick();
                data  = 8'hB2; tick();
                data  = 8'hC3; tick();
                valid = 1'b0;
                repeat (38) tick();
                checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL simul_count_before: got %0d expected 2", fifo_count); end
                data  = 8'hD4;
                valid = 1'b1;
                tick();
                valid = 1'b0;
                data  = 8'h00;
                checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL simul_count_after: got %0d expected 2", fifo_count); end
            end
            begin
                repeat (3) tick();
                check_stream(4, "simul");
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy_end: got %b expected 0", busy); end
            end
        join
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        data  = 8'h3C; valid = 1'b1; tick();
        data  = 8'h11; tick();
        data  = 8'h22; tick();
        valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmid_count_queued: got %0d expected 2", fifo_count); end
        repeat (8) tick();
        // Data bit 1 of 0x3C is on the line here.
        checks++; if (UART_TX !== 1'b0) begin errors++; $display("FAIL rmid_tx_before: got %b expected 0", UART_TX); end
        #1;
        RST_N = 1'b0;
        #1;
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL rmid_tx_reset: got %b expected 1", UART_TX); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count_reset: got %0d expected 0", fifo_count); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_reset: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_reset: got %b expected 0", busy); end
        repeat (2) tick();
        RST_N = 1'b1;
        bad = 0;
        repeat (60) begin
            tick();
            if (UART_TX !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_quiet_after: %0d bad cycles expected 0", bad); end
        data  = 8'h5A; valid = 1'b1; tick();
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) tick();
        exp_q = {8'h5A};
        check_stream(1, "rmid_recover");
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_end: got %b expected 0", busy); end
        repeat (2) tick();
    endtask

    task automatic test_full_toggle();
        exp_q = {8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
        fork
            begin
                int   idx;
                int   cyc;
                int   bad_rdy;
                logic saw_full;
                logic acc;
                idx = 0; cyc = 0; bad_rdy = 0; saw_full = 1'b0;
                while (idx < 6 && cyc < 500) begin
                    valid = ((cyc % 2) == 0) || ((cyc % 7) == 3);
                    data  = valid ? exp_q[idx] : 8'hFF;
                    acc   = valid && ready;
                    if (ready === 1'b0) saw_full = 1'b1;
                    if (ready !== (fifo_count != 3'd4)) bad_rdy++;
                    tick();
                    if (acc) idx++;
                    cyc++;
                end
                valid = 1'b0;
                data  = 8'h00;
                checks++; if (idx != 6) begin errors++; $display("FAIL toggle_accepted: got %0d expected 6", idx); end
                checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL toggle_saw_full: got %b expected 1", saw_full); end
                checks++; if (bad_rdy != 0) begin errors++; $display("FAIL toggle_ready_vs_count: %0d bad cycles expected 0", bad_rdy); end
            end
            begin
                repeat (3) tick();
                check_stream(6, "toggle");
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_busy_end: got %b expected 0", busy); end
            end
        join
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_simul();
        test_reset_mid();
        test_full_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
